piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width and bits per serial frame; elaboration SHALL fail for WIDTH < 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift out bit WIDTH-1 first (feeds a left-shift deserializer in word order); 0 = bit 0 first.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 arst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  WIDTH  parallel word to serialize.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block can accept a word; accept = in_valid && in_ready at posedge.
REQ-008 ser_out  output  1  current serial bit.
REQ-009 ser_valid  output  1  ser_out holds a valid bit.
REQ-010 ser_last  output  1  ser_out is the final bit of the current word.
REQ-011 ser_ready  input  1  downstream consumes bit; bit transfer = ser_valid && ser_ready at posedge.
REQ-012 busy  output  1  equals ser_valid || hold_valid.

Function
REQ-013 Datapath: WIDTH-bit shift register (sreg), bit counter cnt of $clog2(WIDTH) bits, one-word holding register (hold_data, hold_valid).
REQ-014 FSM states IDLE (sreg empty, ser_valid=0) and SHIFT (ser_valid=1).
REQ-015 in_ready SHALL equal !hold_valid, registered-state derived, no combinational path from in_valid or ser_ready.
REQ-016 Accept in IDLE, or in SHIFT coinciding with a last-bit transfer and hold empty: word loads directly into sreg, cnt=0, state SHIFT; first bit on ser_out the cycle after the accepting edge.
REQ-017 Accept in SHIFT otherwise: word stored in hold, hold_valid=1.
REQ-018 ser_out = sreg[WIDTH-1] if MSB_FIRST else sreg[0].
REQ-019 On non-last bit transfer: sreg shifts toward the output end (zero fill), cnt increments.
REQ-020 ser_last = ser_valid && (cnt == WIDTH-1).
REQ-021 On last-bit transfer: if hold_valid, hold_data loads into sreg, cnt=0, hold_valid=0, stay SHIFT; else if accept, per REQ-016; else go IDLE.
REQ-022 ser_ready low: sreg, cnt, ser_out, ser_valid, ser_last SHALL hold unchanged; accepts per REQ-017 still permitted.
REQ-023 Sustained throughput: with in_valid and ser_ready held high, one bit per cycle, no idle cycle between words.
REQ-024 in_data not captured when in_ready low; no word dropped or duplicated.

Reset
REQ-025 arst_n low SHALL asynchronously clear: state IDLE, sreg=0, cnt=0, hold_valid=0, hold_data=0.
REQ-026 Reset output values: ser_out=0, ser_valid=0, ser_last=0, in_ready=1, busy=0.
REQ-027 Reset mid-word SHALL discard the partial word and held word; first accept after release starts a fresh frame at bit 0 of the count.

Structure
REQ-028 Package piso_pkg SHALL hold the state enum typedef (IDLE, SHIFT) and a cnt-width helper function.
REQ-029 Holding register SHALL be sub-module piso_hold_reg (load, clear, data, valid); all else in piso_serializer.

Verification (WIDTH=8)
REQ-030 MSB_FIRST=1, accept 0xA5, ser_ready=1 -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles, ser_last on 8th only, ser_valid=0 after.
REQ-031 in_valid held with 0x3C then 0xC3 -> 16 contiguous valid bits 00111100 11000011, in_ready low from edge after second accept until first word's last transfer.
REQ-032 0xA5 with ser_ready low 3 cycles after bit 3 -> outputs frozen during stall, frame completes in 11 cycles, bit sequence unchanged.
REQ-033 MSB_FIRST=0, accept 0x01 -> first bit 1, then seven 0s, ser_last on 8th.
REQ-034 0xFF, arst_n low after 3 bits -> ser_valid=0, in_ready=1 immediately without clock; after release, 0x80 serializes as 1 then seven 0s.
REQ-035 ser_out into 8-bit left-shift register enabled by ser_valid && ser_ready, word 0xA5 -> register holds 0xA5 the cycle after ser_last transfer.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in / serial-out serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit-counter width; never below one bit so a 2-bit word still has a counter.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-word holding register: lets the serializer accept the next word while the
// current one is still shifting out.
module piso_hold_reg
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with a one-word skid so a continuously
// fed stream leaves no gap between frames.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_ready,
    output logic             busy
);

    if (WIDTH < 2) begin : g_width_check
        $error("piso_serializer: WIDTH must be at least 2");
    end

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   sreg;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hold_data;
    logic               hold_valid;

    logic               accept;
    logic               xfer;
    logic               last_xfer;
    logic               hold_load;
    logic               hold_clear;

    function automatic logic [WIDTH-1:0] shift_toward_out(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return {v[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, v[WIDTH-1:1]};
        end
    endfunction

    // Handshakes depend only on registered state, never on in_valid/ser_ready paths.
    assign in_ready  = !hold_valid;
    assign ser_valid = (state == SHIFT);
    assign ser_out   = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign ser_last  = ser_valid && (cnt == CNT_LAST);
    assign busy      = ser_valid || hold_valid;

    assign accept    = in_valid && in_ready;
    assign xfer      = ser_valid && ser_ready;
    assign last_xfer = xfer && (cnt == CNT_LAST);

    // A word arriving mid-frame parks in the hold unless the frame ends on this edge.
    assign hold_load  = accept && (state == SHIFT) && !last_xfer;
    assign hold_clear = last_xfer && hold_valid;

    piso_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .arst_n    (arst_n),
        .load      (hold_load),
        .clear     (hold_clear),
        .load_data (in_data),
        .data      (hold_data),
        .valid     (hold_valid)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg  <= in_data;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_xfer) begin
                        cnt <= '0;
                        if (hold_valid) begin
                            sreg <= hold_data;
                        end else if (accept) begin
                            sreg <= in_data;
                        end else begin
                            sreg  <= '0;
                            state <= IDLE;
                        end
                    end else if (xfer) begin
                        sreg <= shift_toward_out(sreg);
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    hold_only_while_shifting: assert property (
        @(posedge clk) disable iff (!arst_n) hold_valid |-> (state == SHIFT)
    );

    cnt_in_range: assert property (
        @(posedge clk) disable iff (!arst_n) cnt <= CNT_LAST
    );

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and
// are checked against a bit-queue model plus directed frame scenarios.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         arst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         ser_ready = 1'b1;

    logic in_ready_m, ser_out_m, ser_valid_m, ser_last_m, busy_m;
    logic in_ready_l, ser_out_l, ser_valid_l, ser_last_l, busy_l;

    int vectors = 0;
    int miscompares = 0;

    bit qm[$];
    bit ql[$];
    logic [7:0] deser;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .arst_n(arst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_m), .ser_out(ser_out_m), .ser_valid(ser_valid_m),
        .ser_last(ser_last_m), .ser_ready(ser_ready), .busy(busy_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .arst_n(arst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
        .ser_last(ser_last_l), .ser_ready(ser_ready), .busy(busy_l)
    );

    // Downstream left-shift deserializer fed by the MSB-first stream.
    always @(posedge clk) begin
        if (ser_valid_m && ser_ready) deser <= {deser[6:0], ser_out_m};
    end

    // Scoreboard: each word is a run of W bits in a queue; outstanding words = ceil(size/W).
    initial begin
        bit exp_valid, exp_ready, exp_last, xfer, acc;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                vectors++;
                if ({in_ready_m, ser_out_m, ser_valid_m, ser_last_m, busy_m,
                     in_ready_l, ser_out_l, ser_valid_l, ser_last_l, busy_l} !== 10'b10000_10000) begin
                    miscompares++;
                    $display("FAIL sb_reset got %b%b%b%b%b_%b%b%b%b%b want 10000_10000",
                             in_ready_m, ser_out_m, ser_valid_m, ser_last_m, busy_m,
                             in_ready_l, ser_out_l, ser_valid_l, ser_last_l, busy_l);
                end
                qm.delete();
                ql.delete();
            end else begin
                exp_valid = (qm.size() != 0);
                exp_ready = (qm.size() <= W);
                exp_last  = exp_valid && ((qm.size() % W) == 1);
                vectors++;
                if ({ser_valid_m, busy_m, in_ready_m, ser_last_m,
                     ser_valid_l, busy_l, in_ready_l, ser_last_l} !==
                    {exp_valid, exp_valid, exp_ready, exp_last,
                     exp_valid, exp_valid, exp_ready, exp_last}) begin
                    miscompares++;
                    $display("FAIL sb_ctrl t=%0t got v/b/r/l m=%b%b%b%b l=%b%b%b%b want %b%b%b%b",
                             $time, ser_valid_m, busy_m, in_ready_m, ser_last_m,
                             ser_valid_l, busy_l, in_ready_l, ser_last_l,
                             exp_valid, exp_valid, exp_ready, exp_last);
                end
                if (exp_valid) begin
                    vectors++;
                    if ({ser_out_m, ser_out_l} !== {qm[0], ql[0]}) begin
                        miscompares++;
                        $display("FAIL sb_bit t=%0t got m=%b l=%b want m=%b l=%b",
                                 $time, ser_out_m, ser_out_l, qm[0], ql[0]);
                    end
                end
                xfer = exp_valid && (ser_ready === 1'b1);
                acc  = (in_valid === 1'b1) && exp_ready;
                if (xfer) begin
                    void'(qm.pop_front());
                    void'(ql.pop_front());
                end
                if (acc) begin
                    for (int b = 0; b < W; b++) begin
                        qm.push_back(in_data[W-1-b]);
                        ql.push_back(in_data[b]);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if ({ser_valid_m, ser_last_m, ser_out_m, in_ready_m, busy_m,
             ser_valid_l, in_ready_l, busy_l} !== 8'b00010_010) begin
            miscompares++;
            $display("FAIL reset_values got %b%b%b%b%b_%b%b%b want 00010_010",
                     ser_valid_m, ser_last_m, ser_out_m, in_ready_m, busy_m,
                     ser_valid_l, in_ready_l, busy_l);
        end
        @(negedge clk);
        #2 arst_n = 1'b1;
        tick;
    endtask

    task automatic test_msb_a5;
        logic [7:0] w;
        w = 8'hA5;
        in_data = w; in_valid = 1'b1; ser_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if ({ser_valid_m, ser_out_m, ser_last_m} !== {1'b1, w[7-i], (i == 7)}) begin
                miscompares++;
                $display("FAIL msb_a5 bit%0d got v/o/l=%b%b%b want %b%b%b", i,
                         ser_valid_m, ser_out_m, ser_last_m, 1'b1, w[7-i], (i == 7));
            end
            tick;
        end
        @(negedge clk);
        vectors++;
        if (ser_valid_m !== 1'b0) begin
            miscompares++;
            $display("FAIL msb_a5_end ser_valid got %b want 0", ser_valid_m);
        end
        vectors++;
        if (deser !== 8'hA5) begin
            miscompares++;
            $display("FAIL deser_a5 got %h want a5", deser);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [15:0] w;
        bit exp_rdy;
        w = 16'h3CC3;
        in_data = 8'h3C; in_valid = 1'b1; ser_ready = 1'b1;
        tick;
        in_data = 8'hC3;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_rdy = (i == 0) || (i >= 8);
            vectors++;
            if ({ser_valid_m, ser_out_m, in_ready_m, ser_last_m} !==
                {1'b1, w[15-i], exp_rdy, (i == 7) || (i == 15)}) begin
                miscompares++;
                $display("FAIL b2b bit%0d got v/o/r/l=%b%b%b%b want %b%b%b%b", i,
                         ser_valid_m, ser_out_m, in_ready_m, ser_last_m,
                         1'b1, w[15-i], exp_rdy, (i == 7) || (i == 15));
            end
            tick;
            if (i == 0) in_valid = 1'b0;
        end
        @(negedge clk);
        vectors++;
        if (ser_valid_m !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end ser_valid got %b want 0", ser_valid_m);
        end
        tick;
    endtask

    task automatic test_stall;
        logic [7:0] w;
        int idx;
        w = 8'hA5;
        in_data = w; in_valid = 1'b1; ser_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int c = 0; c < 11; c++) begin
            ser_ready = !(c >= 3 && c <= 5);
            idx = (c < 3) ? c : ((c < 6) ? 3 : c - 3);
            @(negedge clk);
            vectors++;
            if ({ser_valid_m, ser_out_m, ser_last_m} !== {1'b1, w[7-idx], (c == 10)}) begin
                miscompares++;
                $display("FAIL stall cyc%0d got v/o/l=%b%b%b want %b%b%b", c,
                         ser_valid_m, ser_out_m, ser_last_m, 1'b1, w[7-idx], (c == 10));
            end
            tick;
        end
        ser_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ser_valid_m, deser} !== {1'b0, 8'hA5}) begin
            miscompares++;
            $display("FAIL stall_end got v=%b deser=%h want v=0 deser=a5", ser_valid_m, deser);
        end
        tick;
    endtask

    task automatic test_lsb_first;
        in_data = 8'h01; in_valid = 1'b1; ser_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if ({ser_valid_l, ser_out_l, ser_last_l} !== {1'b1, (i == 0), (i == 7)}) begin
                miscompares++;
                $display("FAIL lsb_01 bit%0d got v/o/l=%b%b%b want %b%b%b", i,
                         ser_valid_l, ser_out_l, ser_last_l, 1'b1, (i == 0), (i == 7));
            end
            tick;
        end
        @(negedge clk);
        vectors++;
        if (ser_valid_l !== 1'b0) begin
            miscompares++;
            $display("FAIL lsb_end ser_valid got %b want 0", ser_valid_l);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        in_data = 8'hFF; in_valid = 1'b1; ser_ready = 1'b1;
        tick;
        in_data = 8'h55;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        vectors++;
        if ({ser_valid_m, in_ready_m} !== 2'b10) begin
            miscompares++;
            $display("FAIL mid_pre got v/r=%b%b want 10", ser_valid_m, in_ready_m);
        end
        #2 arst_n = 1'b0;
        #1;
        vectors++;
        if ({ser_valid_m, in_ready_m, busy_m, ser_valid_l, in_ready_l, busy_l} !== 6'b010_010) begin
            miscompares++;
            $display("FAIL mid_async got %b%b%b_%b%b%b want 010_010",
                     ser_valid_m, in_ready_m, busy_m, ser_valid_l, in_ready_l, busy_l);
        end
        @(negedge clk);
        #2 arst_n = 1'b1;
        tick;
        in_data = 8'h80; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if ({ser_valid_m, ser_out_m, ser_last_m} !== {1'b1, (i == 0), (i == 7)}) begin
                miscompares++;
                $display("FAIL mid_80 bit%0d got v/o/l=%b%b%b want %b%b%b", i,
                         ser_valid_m, ser_out_m, ser_last_m, 1'b1, (i == 0), (i == 7));
            end
            tick;
        end
        @(negedge clk);
        vectors++;
        if (ser_valid_m !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_end ser_valid got %b want 0", ser_valid_m);
        end
        tick;
    endtask

    task automatic test_random;
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_data   = 8'($urandom);
            ser_ready = ($urandom_range(0, 3) != 0);
            tick;
        end
        in_valid = 1'b0;
        ser_ready = 1'b1;
        repeat (40) tick;
        @(negedge clk);
        vectors++;
        if ((qm.size() != 0) || (ser_valid_m !== 1'b0) || (ser_valid_l !== 1'b0)) begin
            miscompares++;
            $display("FAIL random_drain got queued=%0d v_m=%b v_l=%b want 0 0 0",
                     qm.size(), ser_valid_m, ser_valid_l);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_msb_a5;
        test_back_to_back;
        test_stall;
        test_lsb_first;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
